// File: rtl/hdc_pkg.sv
// Shared hyperdimensional-encoder constants and the bundler sequencer state type.
package hdc_pkg;

    // Features folded into each hypervector bit by the sequential bundler.
    localparam int FEATURE_COUNT      = 40;
    // Accumulation steps per bundling pass; the bundler consumes
    // FEATURE_COUNT / SEQ_BUNDLER_CYCLES features per step.
    localparam int SEQ_BUNDLER_CYCLES = 10;
    // Popcount at or above which the bundled bit is 1.
    localparam int ENCODING_BIT_THR   = 20;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        THRESH,
        CAPTURE,
        VALID
    } bseq_state_t;

endpackage

// File: rtl/bundler_sequencer.sv
// Initiator-side sequencer for the sequential bundler: runs one bundling pass
// per hypervector dimension and assembles the thresholded bits into hv_out.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | waiting for start; bundler disabled
//   CLEAR   | one cycle with start_bundling low to zero the accumulator
//   ACCUM   | sel walks 0..SEQ_BUNDLER_CYCLES-1, accumulating feature chunks
//   THRESH  | sel parks on the zero mux input; bundler registers its bit
//   CAPTURE | latch thresholded bit into hv_out[dim_idx]; also clears accum
//   VALID   | hv_out complete; bundler held; wait for hv_ready
//
// Every output is a flop, so each *_d value is the output that belongs to
// state_d, not to the current state.
module bundler_sequencer
    import hdc_pkg::*;
#(
    parameter int HV_DIM = 64,
    localparam int DIM_W = $clog2(HV_DIM)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic [DIM_W-1:0]  dim_idx,
    output logic              bnd_en,
    output logic              bnd_start_bundling,
    output logic [3:0]        bnd_sel,
    input  logic              bnd_thresholded_bit,
    output logic [HV_DIM-1:0] hv_out,
    output logic              hv_valid,
    input  logic              hv_ready
);

    if (SEQ_BUNDLER_CYCLES > 15) begin : g_sel_width_check
        $error("SEQ_BUNDLER_CYCLES must fit the 4-bit sel counter");
    end

    if (HV_DIM < 2) begin : g_hv_dim_check
        $error("HV_DIM must be at least 2");
    end

    localparam logic [3:0]       SEL_LAST   = 4'(SEQ_BUNDLER_CYCLES - 1);
    localparam logic [3:0]       SEL_THRESH = 4'(SEQ_BUNDLER_CYCLES);
    localparam logic [DIM_W-1:0] DIM_LAST   = DIM_W'(HV_DIM - 1);

    bseq_state_t       state_q, state_d;
    logic [3:0]        sel_q, sel_d;
    logic [DIM_W-1:0]  dim_q, dim_d;
    logic [HV_DIM-1:0] hv_q, hv_d;
    logic              valid_q, valid_d;
    logic              en_q, en_d;
    logic              sb_q, sb_d;
    logic              busy_q, busy_d;

    // Next-state and next-output decode for the sequencing FSM.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dim_d   = dim_q;
        hv_d    = hv_q;
        valid_d = valid_q;
        en_d    = en_q;
        sb_d    = sb_q;

        case (state_q)
            IDLE: begin
                en_d = 1'b0;
                // abort outranks start even here, so a simultaneous pair never launches a job
                if (start && !abort) begin
                    state_d = CLEAR;
                    dim_d   = '0;
                    hv_d    = '0;
                    en_d    = 1'b1;
                    sb_d    = 1'b0;
                    sel_d   = '0;
                    valid_d = 1'b0;
                end
            end
            CLEAR: begin
                state_d = ACCUM;
                en_d    = 1'b1;
                sb_d    = 1'b1;
                sel_d   = '0;
            end
            ACCUM: begin
                en_d = 1'b1;
                sb_d = 1'b1;
                if (sel_q == SEL_LAST) begin
                    state_d = THRESH;
                    sel_d   = SEL_THRESH;
                end else begin
                    sel_d = sel_q + 4'd1;
                end
            end
            THRESH: begin
                state_d = CAPTURE;
                en_d    = 1'b1;
                sb_d    = 1'b0;
                sel_d   = '0;
            end
            CAPTURE: begin
                hv_d[dim_q] = bnd_thresholded_bit;
                if (dim_q == DIM_LAST) begin
                    state_d = VALID;
                    valid_d = 1'b1;
                    en_d    = 1'b0;
                    sb_d    = 1'b0;
                    sel_d   = '0;
                end else begin
                    // the CAPTURE cycle already zeroed the accumulator, so go straight to ACCUM
                    state_d = ACCUM;
                    dim_d   = dim_q + DIM_W'(1);
                    en_d    = 1'b1;
                    sb_d    = 1'b1;
                    sel_d   = '0;
                end
            end
            VALID: begin
                en_d = 1'b0;
                if (hv_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                en_d    = 1'b0;
                sb_d    = 1'b0;
                sel_d   = '0;
            end
        endcase

        // abort leaves the bundler accumulator dirty; the next CLEAR scrubs it
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            valid_d = 1'b0;
            en_d    = 1'b0;
            sb_d    = 1'b0;
            sel_d   = '0;
            dim_d   = '0;
            hv_d    = hv_q;
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            dim_q   <= '0;
            hv_q    <= '0;
            valid_q <= 1'b0;
            en_q    <= 1'b0;
            sb_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dim_q   <= dim_d;
            hv_q    <= hv_d;
            valid_q <= valid_d;
            en_q    <= en_d;
            sb_q    <= sb_d;
            busy_q  <= busy_d;
        end
    end

    assign busy               = busy_q;
    assign dim_idx            = dim_q;
    assign bnd_en             = en_q;
    assign bnd_start_bundling = sb_q;
    assign bnd_sel            = sel_q;
    assign hv_out             = hv_q;
    assign hv_valid           = valid_q;

endmodule

// File: tb/tb_bundler_sequencer.sv
// Bench for bundler_sequencer: a bundler stand-in driven by the DUT, a
// job-level reference model, a per-cycle compare, directed cases and random jobs.
module tb_bundler_sequencer;
    import hdc_pkg::*;

    localparam int H       = 4;
    localparam int DW      = $clog2(H);
    localparam int PER_DIM = SEQ_BUNDLER_CYCLES + 2;
    localparam int K_VALID = 2 + PER_DIM * H;
    localparam int CH      = FEATURE_COUNT / SEQ_BUNDLER_CYCLES;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          hv_ready = 1'b0;
    logic          busy;
    logic [DW-1:0] dim_idx;
    logic          bnd_en;
    logic          bnd_sb;
    logic [3:0]    bnd_sel;
    logic          bnd_thr = 1'b0;
    logic [H-1:0]  hv_out;
    logic          hv_valid;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    bundler_sequencer #(.HV_DIM(H)) dut (
        .clk                 (clk),
        .nrst                (nrst),
        .start               (start),
        .abort               (abort),
        .busy                (busy),
        .dim_idx             (dim_idx),
        .bnd_en              (bnd_en),
        .bnd_start_bundling  (bnd_sb),
        .bnd_sel             (bnd_sel),
        .bnd_thresholded_bit (bnd_thr),
        .hv_out              (hv_out),
        .hv_valid            (hv_valid),
        .hv_ready            (hv_ready)
    );

    // Upstream features per dimension and a bundler stand-in reacting to the DUT's controls.
    logic [FEATURE_COUNT-1:0] feat [H];
    int bnd_sum = 0;

    always @(posedge clk) begin
        cyc++;
    end

    always @(posedge clk) begin
        if (bnd_en) begin
            if (!bnd_sb)
                bnd_sum <= 0;
            else if (int'(bnd_sel) < SEQ_BUNDLER_CYCLES)
                bnd_sum <= bnd_sum + $countones(feat[dim_idx][int'(bnd_sel)*CH +: CH]);
            if (bnd_sb && int'(bnd_sel) == SEQ_BUNDLER_CYCLES)
                bnd_thr <= (bnd_sum >= ENCODING_BIT_THR);
        end
    end

    // Reference model: a job is just "cycles since start"; outputs follow from that count.
    logic [H-1:0]  ref_hv = '0;
    logic [H-1:0]  m_hv_hold = '0;
    logic [DW-1:0] m_dim_hold = '0;
    bit            m_active = 1'b0;
    int            m_k = 0;

    function automatic logic [H-1:0] hv_upto(int k);
        logic [H-1:0] r = '0;
        for (int d = 0; d < H; d++)
            if (k >= (d + 1) * PER_DIM + 2) r[d] = ref_hv[d];
        return r;
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_active   = 1'b0;
            m_k        = 0;
            m_hv_hold  = '0;
            m_dim_hold = '0;
        end else if (m_active) begin
            if (abort) begin
                m_hv_hold  = hv_upto(m_k);
                m_dim_hold = '0;
                m_active   = 1'b0;
            end else if (m_k >= K_VALID) begin
                if (hv_ready) begin
                    m_hv_hold  = ref_hv;
                    m_dim_hold = DW'(H - 1);
                    m_active   = 1'b0;
                end
            end else begin
                m_k++;
            end
        end else if (start) begin
            m_active = 1'b1;
            m_k      = 1;
            for (int d = 0; d < H; d++)
                ref_hv[d] = ($countones(feat[d]) >= ENCODING_BIT_THR);
        end
    end

    typedef struct packed {
        logic          busy;
        logic [DW-1:0] dim;
        logic          en;
        logic          sb;
        logic [3:0]    sel;
        logic          valid;
        logic [H-1:0]  hv;
    } outs_t;

    function automatic outs_t model_outs();
        outs_t o = '0;
        int    j;
        if (!m_active) begin
            o.hv  = m_hv_hold;
            o.dim = m_dim_hold;
            return o;
        end
        o.busy = 1'b1;
        o.hv   = hv_upto(m_k);
        if (m_k >= K_VALID) begin
            o.valid = 1'b1;
            o.dim   = DW'(H - 1);
        end else if (m_k == 1) begin
            o.en = 1'b1;
        end else begin
            j     = (m_k - 2) % PER_DIM;
            o.dim = DW'((m_k - 2) / PER_DIM);
            o.en  = 1'b1;
            if (j <= SEQ_BUNDLER_CYCLES) begin
                o.sb  = 1'b1;
                o.sel = 4'(j);
            end
        end
        return o;
    endfunction

    // Per-cycle compare of every DUT output against the model, away from the rising edge.
    always @(negedge clk) begin
        outs_t e;
        outs_t a;
        e = model_outs();
        a = {busy, dim_idx, bnd_en, bnd_sb, bnd_sel, hv_valid, hv_out};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL cycle_cmp cyc=%0d got busy=%b dim=%0d en=%b sb=%b sel=%0d valid=%b hv=%b, want busy=%b dim=%0d en=%b sb=%b sel=%0d valid=%b hv=%b",
                     cyc, a.busy, a.dim, a.en, a.sb, a.sel, a.valid, a.hv,
                     e.busy, e.dim, e.en, e.sb, e.sel, e.valid, e.hv);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fill_feat(input int d, input int n);
        logic [FEATURE_COUNT-1:0] v = '0;
        while ($countones(v) < n) v[$urandom_range(FEATURE_COUNT - 1)] = 1'b1;
        feat[d] = v;
    endtask

    task automatic set_counts(input int c0, input int c1, input int c2, input int c3);
        fill_feat(0, c0);
        fill_feat(1, c1);
        fill_feat(2, c2);
        fill_feat(3, c3);
    endtask

    // Called just after a negedge: pulses start for one cycle, returns the start cycle.
    task automatic start_job(output int t0);
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int t0, output int lat);
        int n = 0;
        while (!hv_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        lat = cyc - t0;
        if (!hv_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL valid_timeout: hv_valid low after %0d cycles", n);
        end
    endtask

    task automatic accept();
        hv_ready = 1'b1;
        @(negedge clk);
        hv_ready = 1'b0;
    endtask

    task automatic directed_job(input string name, input logic [3:0] want);
        int t0;
        int lat;
        start_job(t0);
        wait_valid(t0, lat);
        check({name, "_latency"}, lat, K_VALID);
        check({name, "_hv"}, 32'(hv_out), 32'(want));
        accept();
    endtask

    function automatic int pick_count();
        case ($urandom_range(0, 5))
            0: return ENCODING_BIT_THR - 1;
            1: return ENCODING_BIT_THR;
            2: return ENCODING_BIT_THR + 1;
            default: return $urandom_range(0, FEATURE_COUNT);
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int lat;
        int n;
        int abort_at;
        bit seen_valid;

        for (int d = 0; d < H; d++) feat[d] = '0;

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({busy, dim_idx, bnd_en, bnd_sb, bnd_sel, hv_valid, hv_out}), 32'd0);
        #2 nrst = 1'b1;
        @(negedge clk);

        // all ones: 40 per dimension, sel trace checked every cycle by the model compare
        set_counts(40, 40, 40, 40);
        directed_job("all_ones", 4'b1111);
        @(negedge clk);

        // alternating dimensions, no carry-over between passes
        set_counts(40, 0, 40, 0);
        directed_job("alt_0101", 4'b0101);

        // threshold boundary
        set_counts(20, 20, 20, 20);
        directed_job("thr_20", 4'b1111);
        set_counts(19, 19, 19, 19);
        directed_job("thr_19", 4'b0000);
        set_counts(20, 19, 21, 0);
        directed_job("thr_mix", 4'b0101);

        // hv_ready stall for 7 cycles, accept on the 8th with start ignored
        set_counts(25, 10, 30, 5);
        start_job(t0);
        wait_valid(t0, lat);
        for (int i = 0; i < 7; i++) begin
            check("stall_valid", 32'(hv_valid), 32'd1);
            check("stall_hv", 32'(hv_out), 32'b0101);
            check("stall_en", 32'(bnd_en), 32'd0);
            @(negedge clk);
        end
        hv_ready = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        hv_ready = 1'b0;
        start    = 1'b0;
        check("accept_busy", 32'(busy), 32'd0);
        check("accept_valid", 32'(hv_valid), 32'd0);
        @(negedge clk);
        check("accept_start_ignored", 32'(busy), 32'd0);

        // abort during dim 2 accumulation
        set_counts(40, 0, 40, 40);
        start_job(t0);
        n = 0;
        while (!(dim_idx == DW'(2) && bnd_sb && bnd_sel == 4'd3) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach", 32'(n < 200), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dim", 32'(dim_idx), 32'd0);
        check("abort_sel_en", 32'({bnd_en, bnd_sel}), 32'd0);
        check("abort_hv_kept", 32'(hv_out), 32'b0001);
        seen_valid = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (hv_valid) seen_valid = 1'b1;
        end
        check("abort_no_valid", 32'(seen_valid), 32'd0);
        set_counts(0, 40, 0, 40);
        directed_job("after_abort", 4'b1010);

        // reset pulse in the middle of THRESH
        set_counts(40, 40, 0, 20);
        start_job(t0);
        n = 0;
        while (bnd_sel != 4'(SEQ_BUNDLER_CYCLES) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("thresh_reach", 32'(n < 200), 32'd1);
        #2 nrst = 1'b0;
        #1 check("midjob_reset", 32'({busy, dim_idx, bnd_en, bnd_sb, bnd_sel, hv_valid, hv_out}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 nrst = 1'b1;
        @(negedge clk);
        set_counts(40, 0, 40, 20);
        directed_job("after_reset", 4'b1101);

        // random jobs with random stalls, stray start/ready and occasional aborts
        for (int job = 0; job < 30; job++) begin
            for (int d = 0; d < H; d++) fill_feat(d, pick_count());
            repeat ($urandom_range(0, 3)) @(negedge clk);
            abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 55)) : -1;
            start = 1'b1;
            for (n = 0; n < 300; n++) begin
                @(negedge clk);
                if (!busy) break;
                start    = 1'($urandom_range(0, 1));
                abort    = (n + 1 == abort_at);
                hv_ready = ($urandom_range(0, 2) == 0);
            end
            start    = 1'b0;
            abort    = 1'b0;
            hv_ready = 1'b0;
            if (n >= 300) begin
                vectors++;
                miscompares++;
                $display("FAIL random_job_timeout: job %0d still busy", job);
            end
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bundler_sequencer.md
Name: bundler_sequencer

Overview:
Initiator-side controller for the sequential bundler. It drives en, start_bundling and sel through one full bundling pass per hypervector dimension, and presents dim_idx so the upstream binding logic supplies that dimension's bits_to_bundle. It samples the thresholded bit after each pass and assembles the bits into an HV_DIM-bit hypervector, which it hands downstream with a valid/ready handshake. It sits beside the bundler in the encoder top level.

Parameters:
HV_DIM, 64, hypervector dimensions assembled per job (>=2)
DIM_W, $clog2(HV_DIM), width of dim_idx (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
nrst  in  1  asynchronous active-low reset
start  in  1  job request; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE next cycle
busy  out  1  high in every state except IDLE
dim_idx  out  DIM_W  dimension currently being bundled; upstream selects bits_to_bundle from it
bnd_en  out  1  drives bundler en
bnd_start_bundling  out  1  drives bundler start_bundling
bnd_sel  out  4  drives bundler sel
bnd_thresholded_bit  in  1  bundler thresholded_bit
hv_out  out  HV_DIM  assembled hypervector; bit d = dimension d
hv_valid  out  1  hv_out complete and stable
hv_ready  in  1  downstream accept

Behaviour:
- Reset (async, nrst=0): state=IDLE; dim_idx=0, hv_out=0, hv_valid=0, busy=0, bnd_en=0, bnd_start_bundling=0, bnd_sel=0. All outputs are registered.
- States:
  - IDLE: bnd_en=0. If start=1, go to CLEAR and clear dim_idx and hv_out.
  - CLEAR (1 cycle): bnd_en=1, start_bundling=0, sel=0, which zeroes the bundler accumulator. Go to ACCUM with sel=0.
  - ACCUM (SEQ_BUNDLER_CYCLES cycles): bnd_en=1, start_bundling=1, sel steps 0..SEQ_BUNDLER_CYCLES-1, incrementing by 1 each cycle. After the last step go to THRESH.
  - THRESH (1 cycle): sel=SEQ_BUNDLER_CYCLES, start_bundling=1 (the mux outputs 0, so the sum is unchanged). The bundler registers thresholded_bit at the end of this cycle.
  - CAPTURE (1 cycle): bnd_en=1, start_bundling=0, sel=0. hv_out[dim_idx] <= bnd_thresholded_bit. This cycle also clears the accumulator for the next dimension.
    - If dim_idx==HV_DIM-1: go to VALID.
    - Else: dim_idx+1, then ACCUM.
  - VALID: hv_valid=1, bnd_en=0 (bundler holds), hv_out and dim_idx stable. On hv_valid&&hv_ready: hv_valid=0, go to IDLE.
- Timing: 12 cycles per dimension (SEQ_BUNDLER_CYCLES=10). If start is sampled at cycle t:
  - CLEAR occurs at t+1.
  - hv_valid rises at t+2+12*HV_DIM.
- dim_idx changes only on leaving CAPTURE, so bits_to_bundle must be stable from the first ACCUM cycle through THRESH of each dimension.
- Handshake:
  - hv_valid never drops without hv_ready.
  - hv_ready outside VALID is ignored.
  - start is ignored while busy, including in the handshake cycle; a new job needs start in IDLE.
- abort (any non-IDLE state): next cycle state=IDLE, hv_valid=0, bnd_en=0, sel=0, dim_idx=0, hv_out retained.
  - abort has priority over the hv_ready handshake and over start.
  - The bundler accumulator is left dirty; the next job's CLEAR fixes it.
- Reset mid-job: immediate return to the reset values above; no partial hypervector is emitted.
- Widths: the sel counter is 4 bits. SEQ_BUNDLER_CYCLES<=15 is enforced by an elaboration-time check.

Decomposition:
- Shared package hdc_pkg holds FEATURE_COUNT, SEQ_BUNDLER_CYCLES and ENCODING_BIT_THR.
- This block adds to hdc_pkg the enumerated typedef bseq_state_t {IDLE, CLEAR, ACCUM, THRESH, CAPTURE, VALID}.
- No sub-module: a single FSM with a sel counter and dim_idx counter. The bundler is instantiated alongside, at the encoder top level.

Test Plan:
1. HV_DIM=4, features all ones, ENCODING_BIT_THR=20, start at t -> sum=40 each dimension; hv_out=4'b1111 and hv_valid at t+50; bnd_sel trace 0..10 per dimension.
2. HV_DIM=4, upstream gives ones for dim 0 and 2 and zeros for dim 1 and 3 -> hv_out=4'b0101; each dimension's accumulator starts from 0 (no carry-over).
3. Exactly 20 ones per dimension (the threshold boundary) -> all bits 1; 19 ones -> all bits 0.
4. hv_ready held low for 7 cycles after hv_valid -> hv_valid and hv_out stable for all 7, bnd_en=0; accepted on cycle 8; IDLE next cycle; start in the accept cycle ignored.
5. abort asserted in ACCUM of dim 2 -> IDLE next cycle, hv_valid never rises. A new start then yields the correct hv_out with no residue from the aborted job.
6. nrst pulsed low mid-THRESH -> all outputs 0 immediately; after release, a normal job completes with the expected hv_out at t+50.
